dac_serial_tx: RTL and testbench
================================

# dac_serial_tx

Serial DAC transmitter for the sound path: accepts one 10-bit DAC code per `load` pulse from the sample processor's registered output and shifts it MSB-first to an MCP4911-style SPI DAC as a 16-bit write frame. It generates chip-select, serial clock and the latch (LDAC) strobe. It sits between the processor's `data_out` register and the board DAC pins, and reports `busy` so the sample-rate controller knows when the next code may be issued.

## Interface

- `CLK_DIV`, 8: sysclk cycles per half SCK period; legal range 1..255.
- `BUF`, 1: frame bit 14, the DAC reference-buffer enable.
- `GA_N`, 1: frame bit 13, gain select, active-low (1 = 1x).
- `SHDN_N`, 1: frame bit 12, output enable, active-low shutdown.
- `sysclk`  input  1  system clock; the block's only clock; all logic on its rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `data_in`  input  10  DAC code, offset-binary, already offset by the processor; sampled only on an accepted load.
- `load`  input  1  request to send `data_in`; level sampled each cycle.
- `busy`  output  1  high from the accepted load until the frame and LDAC pulse complete.
- `dac_cs_n`  output  1  chip select, active-low.
- `dac_sck`  output  1  serial clock, idle low.
- `dac_sdi`  output  1  serial data to the DAC.
- `dac_ld_n`  output  1  DAC latch strobe, active-low.

## Operation

- The frame is {1'b0, BUF, GA_N, SHDN_N, data_in[9:0], 2'b00}, shifted MSB first. Bit 15 is always 0 (the write command).
- The FSM has four states: IDLE, SHIFT, GAP, LATCH.
- A free-running divider is held at 0 outside SHIFT, GAP and LATCH. It produces a tick every CLK_DIV cycles.
- **IDLE.** If `load` is high at the edge:
  - capture the frame into a 16-bit shift register;
  - `dac_cs_n`<=0, `dac_sdi`<=frame[15], `busy`<=1, `dac_sck`=0;
  - clear the divider and the bit counter, then go to SHIFT.
- **SHIFT.** Each tick toggles `dac_sck`.
  - On a 0->1 toggle, data is unchanged; the DAC samples here.
  - On a 1->0 toggle, shift left and drive the next bit on `dac_sdi`.
  - The bit counter increments on each falling toggle.
  - On the 16th falling toggle: `dac_cs_n`<=1, `dac_sdi`<=0, go to GAP.
- **GAP.** Wait one tick with all lines idle. On the tick, `dac_ld_n`<=0 and go to LATCH.
- **LATCH.** On the tick: `dac_ld_n`<=1, `busy`<=0, go to IDLE.
- `load` is accepted only when the state is IDLE at that edge. Requests in any other state are dropped; there is no queuing.
- `data_in` changes while busy have no effect on the frame in flight.
- Reset (async, any state) forces the idle values at once. A partial frame is abandoned and is not latched, because `dac_ld_n` never pulses for it.

## Timing

- Reset values:
  - `busy`=0, `dac_cs_n`=1, `dac_sck`=0, `dac_sdi`=0, `dac_ld_n`=1;
  - FSM in IDLE; shift register, divider and bit counter all 0.
- With edge 0 being the accepted `load` edge:
  - `dac_cs_n` falls and frame[15] appears at edge 0;
  - SCK rising edge n (n = 1..16) occurs at edge (2n-1)*CLK_DIV;
  - SCK falling edge n occurs at edge 2n*CLK_DIV;
  - `dac_cs_n` rises at edge 32*CLK_DIV;
  - `dac_ld_n` is low from edge 33*CLK_DIV to edge 34*CLK_DIV (exactly CLK_DIV cycles);
  - `busy` is high for 34*CLK_DIV cycles.
- Bit k of the frame (15 down to 0) is stable on `dac_sdi` for the full cycle window around SCK rising edge 16-k.
- Maximum sample rate is sysclk / (34*CLK_DIV + 1) if `load` is held continuously. The next accept happens one cycle after `busy` falls.
- With CLK_DIV=1, SCK toggles every cycle (sysclk/2); the timing rules above still hold.
- All outputs are registered, with no combinational path from inputs to outputs.

## Test plan

- **Reset.** Assert `rst_n`=0 with random inputs -> `busy`=0, `dac_cs_n`=1, `dac_sck`=0, `dac_sdi`=0, `dac_ld_n`=1. Release reset -> outputs stay idle until `load`.
- **Single frame.** CLK_DIV=2, defaults, `data_in`=10'h2A5, one-cycle `load`:
  - bits captured at SCK rises = 16'h7A94;
  - `dac_cs_n` low for 64 cycles;
  - `dac_ld_n` low for cycles 66..67;
  - `busy` high for 68 cycles.
- **Extremes.** `data_in`=10'h000 -> 16'h7000. `data_in`=10'h3FF -> 16'h7FFC. With parameters BUF=0, SHDN_N=0, `data_in`=10'h3FF -> 16'h2FFC.
- **Load while busy.** Pulse `load` with 10'h155 mid-frame of 10'h2A5 -> only 16'h7A94 is sent, exactly 16 SCK rises, one LDAC pulse. `load` on the cycle `busy` falls is ignored.
- **Back-to-back.** Hold `load` high, CLK_DIV=1, alternate 10'h000/10'h3FF -> frames start every 35 cycles. Decoded frames are 16'h7000 and 16'h7FFC in order.
- **Reset mid-frame.** Drop `rst_n` after 7 SCK rises -> all outputs idle immediately with no `dac_ld_n` pulse. A following load of 10'h0F0 sends 16'h73C0 normally.

Source files
------------

// File: rtl/dac_serial_tx.sv
// rtl/dac_serial_tx.sv - 16-bit SPI write-frame transmitter for an MCP4911-style DAC with LDAC strobe
module dac_serial_tx #(
    parameter int CLK_DIV = 8,
    parameter bit BUF     = 1'b1,
    parameter bit GA_N    = 1'b1,
    parameter bit SHDN_N  = 1'b1
) (
    input  logic       sysclk,
    input  logic       rst_n,
    input  logic [9:0] data_in,
    input  logic       load,
    output logic       busy,
    output logic       dac_cs_n,
    output logic       dac_sck,
    output logic       dac_sdi,
    output logic       dac_ld_n
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2,
        S_LATCH = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] shift_q, shift_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  div_q, div_d;
    logic        busy_q, busy_d;
    logic        cs_n_q, cs_n_d;
    logic        sck_q, sck_d;
    logic        sdi_q, sdi_d;
    logic        ld_n_q, ld_n_d;
    logic        tick;
    logic [15:0] frame;

    assign tick  = (state_q != S_IDLE) && (div_q == DIV_LAST);
    assign frame = {1'b0, BUF, GA_N, SHDN_N, data_in, 2'b00};

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            div_q     <= '0;
            busy_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            sck_q     <= 1'b0;
            sdi_q     <= 1'b0;
            ld_n_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            div_q     <= div_d;
            busy_q    <= busy_d;
            cs_n_q    <= cs_n_d;
            sck_q     <= sck_d;
            sdi_q     <= sdi_d;
            ld_n_q    <= ld_n_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (load) state_d = S_SHIFT;
            S_SHIFT: if (tick && sck_q && (bit_cnt_q == 4'd15)) state_d = S_GAP;
            S_GAP:   if (tick) state_d = S_LATCH;
            S_LATCH: if (tick) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Registered line values; a tick while sck is high is the falling edge that advances the data.
    always_comb begin
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        busy_d    = busy_q;
        cs_n_d    = cs_n_q;
        sck_d     = sck_q;
        sdi_d     = sdi_q;
        ld_n_d    = ld_n_q;
        if (state_q == S_IDLE) begin
            div_d = '0;
        end else begin
            div_d = tick ? 8'd0 : div_q + 8'd1;
        end
        case (state_q)
            S_IDLE: begin
                if (load) begin
                    shift_d   = frame;
                    bit_cnt_d = '0;
                    cs_n_d    = 1'b0;
                    sdi_d     = frame[15];
                    sck_d     = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            S_SHIFT: begin
                if (tick) begin
                    if (!sck_q) begin
                        sck_d = 1'b1;
                    end else begin
                        sck_d     = 1'b0;
                        shift_d   = {shift_q[14:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd15) begin
                            cs_n_d = 1'b1;
                            sdi_d  = 1'b0;
                        end else begin
                            sdi_d = shift_q[14];
                        end
                    end
                end
            end
            S_GAP:   if (tick) ld_n_d = 1'b0;
            S_LATCH: begin
                if (tick) begin
                    ld_n_d = 1'b1;
                    busy_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign busy     = busy_q;
    assign dac_cs_n = cs_n_q;
    assign dac_sck  = sck_q;
    assign dac_sdi  = sdi_q;
    assign dac_ld_n = ld_n_q;

endmodule

// File: tb/tb_dac_serial_tx.sv
// tb/tb_dac_serial_tx.sv - self-checking bench for dac_serial_tx against a frame/timing reference model
module tb_dac_serial_tx;

    localparam int MAXC = 200;

    logic       sysclk  = 1'b0;
    logic       rst_n   = 1'b1;
    logic [9:0] data_in = '0;
    logic       load    = 1'b0;
    logic [1:0] sel     = 2'd0;

    logic [3:0] load_w, busy_w, cs_w, sck_w, sdi_w, ld_w;
    logic       m_busy, m_cs, m_sck, m_sdi, m_ld;

    int errors = 0;
    int checks = 0;

    logic [4:0]  rec [MAXC];
    int          rise_q[$];
    logic [15:0] word_q[$];
    int          cs_fall_q[$];
    int          ld_fall_q[$];
    int          cs_low_cnt, ld_low_cnt, busy_cnt, unstable;

    always #5 sysclk = ~sysclk;

    always_comb begin
        load_w = '0;
        for (int k = 0; k < 4; k++) load_w[k] = load && (sel == 2'(k));
    end

    assign m_busy = busy_w[sel];
    assign m_cs   = cs_w[sel];
    assign m_sck  = sck_w[sel];
    assign m_sdi  = sdi_w[sel];
    assign m_ld   = ld_w[sel];

    dac_serial_tx #(.CLK_DIV(2)) dut_a (
        .sysclk(sysclk), .rst_n(rst_n), .data_in(data_in), .load(load_w[0]),
        .busy(busy_w[0]), .dac_cs_n(cs_w[0]), .dac_sck(sck_w[0]), .dac_sdi(sdi_w[0]), .dac_ld_n(ld_w[0]));
    dac_serial_tx #(.CLK_DIV(1)) dut_b (
        .sysclk(sysclk), .rst_n(rst_n), .data_in(data_in), .load(load_w[1]),
        .busy(busy_w[1]), .dac_cs_n(cs_w[1]), .dac_sck(sck_w[1]), .dac_sdi(sdi_w[1]), .dac_ld_n(ld_w[1]));
    dac_serial_tx #(.CLK_DIV(2), .BUF(1'b0), .GA_N(1'b1), .SHDN_N(1'b0)) dut_c (
        .sysclk(sysclk), .rst_n(rst_n), .data_in(data_in), .load(load_w[2]),
        .busy(busy_w[2]), .dac_cs_n(cs_w[2]), .dac_sck(sck_w[2]), .dac_sdi(sdi_w[2]), .dac_ld_n(ld_w[2]));
    dac_serial_tx #(.CLK_DIV(3)) dut_d (
        .sysclk(sysclk), .rst_n(rst_n), .data_in(data_in), .load(load_w[3]),
        .busy(busy_w[3]), .dac_cs_n(cs_w[3]), .dac_sck(sck_w[3]), .dac_sdi(sdi_w[3]), .dac_ld_n(ld_w[3]));

    function automatic int div_of(input int s);
        return (s == 1) ? 1 : (s == 3) ? 3 : 2;
    endfunction

    function automatic logic [15:0] model_frame(input int s, input int code);
        int b, ga, sh;
        b  = (s == 2) ? 0 : 1;
        ga = 1;
        sh = (s == 2) ? 0 : 1;
        return 16'((b << 14) + (ga << 13) + (sh << 12) + (code << 2));
    endfunction

    task automatic start(input int s, input logic [9:0] code);
        sel     = 2'(s);
        data_in = code;
        load    = 1'b1;
    endtask

    task automatic idle_reset();
        load  = 1'b0;
        rst_n = 1'b0;
        @(negedge sysclk);
        rst_n = 1'b1;
        @(negedge sysclk);
    endtask

    // Index i holds the line values right after the i-th edge, edge 0 being the accepting one.
    task automatic record(input int n, input int p1, input int p2, input logic [9:0] code2, input bit hold_alt);
        int   fcnt;
        logic pcs;
        fcnt = 0;
        pcs  = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge sysclk);
            rec[i] = {m_busy, m_cs, m_sck, m_sdi, m_ld};
            if (hold_alt) begin
                if (!m_cs && pcs) begin
                    fcnt++;
                    data_in = fcnt[0] ? 10'h3FF : 10'h000;
                end
            end else begin
                load = (i + 1 == p1) || (i + 1 == p2);
                if (load) data_in = code2;
            end
            pcs = m_cs;
        end
        load = 1'b0;
    endtask

    task automatic analyze(input int n);
        logic b, c, s, d, l, ps, pc, pl;
        logic [15:0] acc;
        int nb;
        rise_q.delete(); word_q.delete(); cs_fall_q.delete(); ld_fall_q.delete();
        cs_low_cnt = 0; ld_low_cnt = 0; busy_cnt = 0; unstable = 0;
        acc = '0; nb = 0; ps = 1'b0; pc = 1'b1; pl = 1'b1;
        for (int i = 0; i < n; i++) begin
            {b, c, s, d, l} = rec[i];
            if (s && !ps) begin
                rise_q.push_back(i);
                acc = {acc[14:0], d};
                nb++;
                if (i > 0 && rec[i-1][1] !== d) unstable++;
                if (nb == 16) begin
                    word_q.push_back(acc);
                    nb = 0;
                end
            end
            if (!c && pc) cs_fall_q.push_back(i);
            if (!l && pl) ld_fall_q.push_back(i);
            if (!c) cs_low_cnt++;
            if (!l) ld_low_cnt++;
            if (b) busy_cnt++;
            ps = s; pc = c; pl = l;
        end
    endtask

    task automatic test_reset();
        data_in = 10'($urandom);
        load    = 1'($urandom);
        #3 rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge sysclk);
            data_in = 10'($urandom);
            load    = 1'($urandom);
        end
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            #1;
            checks++;
            if ({m_busy, m_cs, m_sck, m_sdi, m_ld} !== 5'b01001) begin
                errors++;
                $display("FAIL reset_idle[%0d]: got %b want 01001", s, {m_busy, m_cs, m_sck, m_sdi, m_ld});
            end
        end
        @(negedge sysclk);
        load  = 1'b0;
        rst_n = 1'b1;
        sel   = 2'd0;
        record(20, -1, -1, 10'h000, 1'b0);
        analyze(20);
        checks++;
        if (busy_cnt + cs_low_cnt + ld_low_cnt + rise_q.size() !== 0) begin
            errors++;
            $display("FAIL post_reset_quiet: activity %0d want 0", busy_cnt + cs_low_cnt + ld_low_cnt + rise_q.size());
        end
    endtask

    task automatic test_single();
        idle_reset();
        start(0, 10'h2A5);
        record(80, -1, -1, 10'h000, 1'b0);
        analyze(80);
        checks++;
        if (word_q.size() != 1 || word_q[0] !== 16'h7A94) begin
            errors++;
            $display("FAIL single_word: got %0d words first %h want 7a94", word_q.size(), (word_q.size() > 0) ? word_q[0] : 16'hxxxx);
        end
        checks++;
        if (cs_low_cnt !== 64 || cs_fall_q.size() != 1 || cs_fall_q[0] !== 0) begin
            errors++;
            $display("FAIL single_cs: low %0d falls %0d want 64 cycles from 0", cs_low_cnt, cs_fall_q.size());
        end
        checks++;
        if (ld_low_cnt !== 2 || ld_fall_q.size() != 1 || ld_fall_q[0] !== 66) begin
            errors++;
            $display("FAIL single_ldac: low %0d pulses %0d want 2 cycles at 66", ld_low_cnt, ld_fall_q.size());
        end
        checks++;
        if (busy_cnt !== 68) begin
            errors++;
            $display("FAIL single_busy: got %0d want 68", busy_cnt);
        end
        checks++;
        if (rise_q.size() != 16 || rise_q[0] !== 2 || rise_q[15] !== 62 || unstable !== 0) begin
            errors++;
            $display("FAIL single_sck: rises %0d unstable %0d want 16 from 2 to 62 stable", rise_q.size(), unstable);
        end
    endtask

    task automatic test_extremes();
        logic [9:0]  codes [3];
        logic [15:0] wants [3];
        int          sels  [3];
        codes = '{10'h000, 10'h3FF, 10'h3FF};
        wants = '{16'h7000, 16'h7FFC, 16'h2FFC};
        sels  = '{0, 0, 2};
        for (int k = 0; k < 3; k++) begin
            idle_reset();
            start(sels[k], codes[k]);
            record(75, -1, -1, 10'h000, 1'b0);
            analyze(75);
            checks++;
            if (word_q.size() != 1 || word_q[0] !== wants[k]) begin
                errors++;
                $display("FAIL extreme[%0d]: got %h want %h", k, (word_q.size() > 0) ? word_q[0] : 16'hxxxx, wants[k]);
            end
        end
    endtask

    task automatic test_random();
        int s, d, n;
        logic [9:0] code;
        logic [15:0] exp_w;
        for (int k = 0; k < 8; k++) begin
            s     = k % 4;
            d     = div_of(s);
            n     = 34 * d + 6;
            code  = 10'($urandom);
            exp_w = model_frame(s, int'(code));
            idle_reset();
            start(s, code);
            record(n, -1, -1, 10'h000, 1'b0);
            analyze(n);
            checks++;
            if (word_q.size() != 1 || word_q[0] !== exp_w) begin
                errors++;
                $display("FAIL random_word[%0d]: got %h want %h", k, (word_q.size() > 0) ? word_q[0] : 16'hxxxx, exp_w);
            end
            checks++;
            if (rise_q.size() != 16 || rise_q[0] !== d || rise_q[15] !== 31 * d || unstable !== 0) begin
                errors++;
                $display("FAIL random_sck[%0d]: rises %0d unstable %0d want 16 from %0d to %0d", k, rise_q.size(), unstable, d, 31 * d);
            end
            checks++;
            if (cs_low_cnt !== 32 * d || busy_cnt !== 34 * d || ld_low_cnt !== d ||
                ld_fall_q.size() != 1 || ld_fall_q[0] !== 33 * d) begin
                errors++;
                $display("FAIL random_timing[%0d]: cs %0d busy %0d ld %0d want %0d %0d %0d", k, cs_low_cnt, busy_cnt, ld_low_cnt, 32 * d, 34 * d, d);
            end
        end
    endtask

    task automatic test_load_while_busy();
        idle_reset();
        start(0, 10'h2A5);
        record(100, 20, 68, 10'h155, 1'b0);
        analyze(100);
        checks++;
        if (word_q.size() != 1 || word_q[0] !== 16'h7A94 || rise_q.size() != 16) begin
            errors++;
            $display("FAIL busy_drop_word: words %0d rises %0d want one 7a94 with 16 rises", word_q.size(), rise_q.size());
        end
        checks++;
        if (cs_fall_q.size() != 1 || ld_fall_q.size() != 1 || busy_cnt !== 68) begin
            errors++;
            $display("FAIL busy_drop_frames: cs %0d ld %0d busy %0d want 1 1 68", cs_fall_q.size(), ld_fall_q.size(), busy_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_w;
        idle_reset();
        start(1, 10'h000);
        record(145, -1, -1, 10'h000, 1'b1);
        analyze(145);
        checks++;
        if (word_q.size() < 4 || cs_fall_q.size() < 4) begin
            errors++;
            $display("FAIL b2b_count: words %0d frames %0d want at least 4", word_q.size(), cs_fall_q.size());
        end else begin
            for (int j = 0; j < 4; j++) begin
                exp_w = model_frame(1, (j % 2 == 1) ? 1023 : 0);
                checks++;
                if (word_q[j] !== exp_w || cs_fall_q[j] !== 35 * j) begin
                    errors++;
                    $display("FAIL b2b_frame[%0d]: got %h at %0d want %h at %0d", j, word_q[j], cs_fall_q[j], exp_w, 35 * j);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ld_seen;
        idle_reset();
        start(0, 10'h2A5);
        record(27, -1, -1, 10'h000, 1'b0);
        analyze(27);
        checks++;
        if (rise_q.size() != 7 || rec[26][3] !== 1'b0) begin
            errors++;
            $display("FAIL mid_partial: rises %0d cs %b want 7 with cs low", rise_q.size(), rec[26][3]);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({m_busy, m_cs, m_sck, m_sdi, m_ld} !== 5'b01001) begin
            errors++;
            $display("FAIL mid_async_idle: got %b want 01001", {m_busy, m_cs, m_sck, m_sdi, m_ld});
        end
        ld_seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge sysclk);
            if (!m_ld) ld_seen = 1'b1;
            load    = 1'($urandom);
            data_in = 10'($urandom);
        end
        load  = 1'b0;
        rst_n = 1'b1;
        record(10, -1, -1, 10'h000, 1'b0);
        analyze(10);
        checks++;
        if (ld_seen || ld_fall_q.size() != 0 || cs_fall_q.size() != 0) begin
            errors++;
            $display("FAIL mid_no_latch: ld_seen %0d ld %0d cs %0d want none", ld_seen, ld_fall_q.size(), cs_fall_q.size());
        end
        start(0, 10'h0F0);
        record(75, -1, -1, 10'h000, 1'b0);
        analyze(75);
        checks++;
        if (word_q.size() != 1 || word_q[0] !== 16'h73C0 || ld_fall_q.size() != 1) begin
            errors++;
            $display("FAIL mid_next_frame: got %h ld %0d want 73c0 with one ldac", (word_q.size() > 0) ? word_q[0] : 16'hxxxx, ld_fall_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_extremes();
        test_random();
        test_load_while_busy();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
